// File: rtl/multimem_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : multimem_ram_if
// Brief    : Write-byte / read-halfword bus bundle for multimem_ram.
// Revision : 1.0 - initial release
// ============================================================================
interface multimem_ram_if #(
  parameter int ADDR_A_WIDTH = 12,
  parameter int ADDR_B_WIDTH = ADDR_A_WIDTH - 1,
  parameter int DATA_A_WIDTH = 8,
  parameter int DATA_B_WIDTH = 2 * DATA_A_WIDTH
);
  logic [DATA_A_WIDTH-1:0] DataInA;
  logic [ADDR_A_WIDTH-1:0] AddressA;
  logic                    ClockEnA;
  logic                    WrA;
  logic [ADDR_B_WIDTH-1:0] AddressB;
  logic                    ClockEnB;
  logic [DATA_B_WIDTH-1:0] QB;

  modport master (
    output DataInA, AddressA, ClockEnA, WrA, AddressB, ClockEnB,
    input  QB
  );

  modport slave (
    input  DataInA, AddressA, ClockEnA, WrA, AddressB, ClockEnB,
    output QB
  );
endinterface
`default_nettype wire

// File: rtl/multimem_ram.sv
`default_nettype none
// ============================================================================
// Module   : multimem_ram
// Brief    : 4096x8 write / 2048x16 registered-read simple dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module multimem_ram #(
  parameter int ADDR_A_WIDTH = 12,
  parameter int ADDR_B_WIDTH = ADDR_A_WIDTH - 1,
  parameter int DATA_A_WIDTH = 8,
  parameter int DATA_B_WIDTH = 2 * DATA_A_WIDTH
) (
  input  wire             Clock,
  input  wire             Reset,
  multimem_ram_if.slave   bus
);
  localparam int C_HALF_DEPTH = 1 << ADDR_B_WIDTH;

  // Storage split into even/odd byte banks so a halfword read is one row of each.
  logic [DATA_A_WIDTH-1:0] mem_even_q [0:C_HALF_DEPTH-1];
  logic [DATA_A_WIDTH-1:0] mem_odd_q  [0:C_HALF_DEPTH-1];

  logic                    w_wr_en;
  logic                    w_wr_even;
  logic                    w_wr_odd;
  logic [ADDR_B_WIDTH-1:0] w_wr_row;
  logic [DATA_B_WIDTH-1:0] qb_d;
  logic [DATA_B_WIDTH-1:0] qb_q;

  always_comb begin
    w_wr_en   = bus.ClockEnA & bus.WrA;
    w_wr_row  = bus.AddressA[ADDR_A_WIDTH-1:1];
    w_wr_even = w_wr_en & ~bus.AddressA[0];
    w_wr_odd  = w_wr_en &  bus.AddressA[0];
  end

  always_ff @(posedge Clock) begin
    if (w_wr_even) begin
      mem_even_q[w_wr_row] <= bus.DataInA;
    end
    if (w_wr_odd) begin
      mem_odd_q[w_wr_row] <= bus.DataInA;
    end
  end

  // Reads see pre-edge contents, giving read-first behaviour on collisions.
  always_comb begin
    qb_d = qb_q;
    if (bus.ClockEnB) begin
      qb_d = {mem_odd_q[bus.AddressB], mem_even_q[bus.AddressB]};
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      qb_q <= '0;
    end else begin
      qb_q <= qb_d;
    end
  end

  assign bus.QB = qb_q;
endmodule
`default_nettype wire

// File: tb/tb_multimem_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_multimem_ram
// Brief    : Scoreboard bench for multimem_ram against a flat byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multimem_ram;
  logic clk;
  logic rst_n;

  multimem_ram_if bus ();

  multimem_ram dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        sb [$];
  logic [7:0]  model [0:4095];
  logic [15:0] exp_prev;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, predict QB, apply the write to the model, check after the edge.
  task automatic cyc(input bit rn, input bit cea, input bit wra, input logic [11:0] aa,
                     input logic [7:0] da, input bit ceb, input logic [10:0] ab, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n        = rn;
    bus.ClockEnA = cea;
    bus.WrA      = wra;
    bus.AddressA = aa;
    bus.DataInA  = da;
    bus.ClockEnB = ceb;
    bus.AddressB = ab;
    if (!rn)      exp_prev = 16'h0000;
    else if (ceb) exp_prev = {model[{ab, 1'b1}], model[{ab, 1'b0}]};
    e.tag = tag;
    e.val = exp_prev;
    sb.push_back(e);
    if (cea && wra) model[aa] = da;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, bus.QB, e.val);
  endtask

  task automatic wr(input logic [11:0] aa, input logic [7:0] da, input string tag);
    cyc(1'b1, 1'b1, 1'b1, aa, da, 1'b0, 11'h000, tag);
  endtask

  task automatic rd(input logic [10:0] ab, input string tag);
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, ab, tag);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    exp_prev     = 16'h0000;
    rst_n        = 1'b1;
    bus.ClockEnA = 1'b0;
    bus.WrA      = 1'b0;
    bus.AddressA = '0;
    bus.DataInA  = '0;
    bus.ClockEnB = 1'b0;
    bus.AddressB = '0;

    cyc(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 11'h000, "reset");
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 11'h123, "hold_after_reset0");
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 11'h7FF, "hold_after_reset1");

    wr(12'hFFF, 8'h41, "wr_A");
    wr(12'hFFE, 8'h42, "wr_B");
    rd(11'h7FF, "pair_4142");

    wr(12'hFFF, 8'h43, "wr_C");
    rd(11'h7FF, "overwrite_4342");

    cyc(1'b1, 1'b1, 1'b1, 12'hFFE, 8'h45, 1'b1, 11'h7FF, "collide_E_old");
    rd(11'h7FF, "collide_E_new");
    cyc(1'b1, 1'b1, 1'b1, 12'hFFE, 8'h46, 1'b1, 11'h7FF, "collide_F_old");
    rd(11'h7FF, "collide_F_new");

    wr(12'h7FF, 8'h5A, "wr_Z");
    wr(12'h7FE, 8'h59, "wr_Y");
    rd(11'h3FF, "lower_5A59");
    rd(11'h7FF, "upper_unchanged");

    cyc(1'b1, 1'b0, 1'b1, 12'hFFF, 8'h00, 1'b0, 11'h000, "cea_gate_wr");
    cyc(1'b1, 1'b1, 1'b0, 12'hFFE, 8'h00, 1'b0, 11'h001, "wra_gate_wr");
    rd(11'h7FF, "gated_mem_unchanged");
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 11'h3FF, "ceb_hold0");
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 11'h000, "ceb_hold1");

    // Reset overrides a read but leaves the write port working.
    cyc(1'b0, 1'b1, 1'b1, 12'h7FF, 8'h77, 1'b1, 11'h3FF, "reset_over_read");
    rd(11'h3FF, "write_during_reset");

    // Randomised traffic over a preloaded window, both bank parities exercised.
    for (int i = 0; i < 64; i++) wr(12'(i), 8'($urandom), "preload");
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          12'($urandom_range(0, 63)), 8'($urandom), ($urandom_range(0, 3) != 0),
          11'($urandom_range(0, 31)), "random");
    end

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/multimem_ram.md
# multimem_ram

Mixed-width simple dual-port RAM: a byte-wide write port (4096 x 8) and a halfword-wide read port (2048 x 16) over the same 32 Kbit storage. Sits between the byte-oriented frame loader (write side) and the LED display scan logic (read side), which fetches two adjacent bytes per access. Fully synchronous to one clock; the read data output is registered.

## Interface
Parameters:
- ADDR_A_WIDTH, 12, write-port byte address width (depth 2^12 bytes)
- ADDR_B_WIDTH, 11, read-port halfword address width; fixed at ADDR_A_WIDTH-1
- DATA_A_WIDTH, 8, write data width
- DATA_B_WIDTH, 16, read data width; fixed at 2*DATA_A_WIDTH

Ports:
- Clock  in  1  sole clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low; clears QB only
- DataInA  in  8  write data
- AddressA  in  12  write byte address
- ClockEnA  in  1  write-port enable
- WrA  in  1  write strobe; write occurs only when ClockEnA=1 and WrA=1
- AddressB  in  11  read halfword address
- ClockEnB  in  1  read-port enable; QB updates only when 1
- QB  out  16  registered read data

## Operation
- Storage: 4096 bytes, mem[0..4095]. Contents not initialised and not affected by Reset.
- Write: at rising edge with ClockEnA=1 and WrA=1, mem[AddressA] <= DataInA. ClockEnA=0 or WrA=0: no write; DataInA/AddressA ignored.
- Read mapping: halfword at AddressB = bytes {AddressB,1} and {AddressB,0}.
  - QB[15:8] = mem[{AddressB,1'b1}] (odd byte)
  - QB[7:0] = mem[{AddressB,1'b0}] (even byte)
- Read: at rising edge with Reset=1 and ClockEnB=1, QB <= {mem[{AddressB,1}], mem[{AddressB,0}]}.
- ClockEnB=0: QB holds its previous value.
- Reset: at rising edge with Reset=0, QB <= 16'h0000 (overrides ClockEnB). Writes remain functional during Reset (write port has no reset).
- Collision (write to either byte of the halfword being read in the same edge): read-first — QB receives the pre-write contents; the new byte is visible to a read on the following edge.
- Write and read ports are independent; simultaneous active write and read on different addresses proceed without interaction.
- Address bits are fully decoded; no wrap-around or out-of-range cases (all 4096/2048 addresses valid).

## Timing
- Write latency: byte committed at edge N; readable by a read sampled at edge N+1 or later.
- Read latency: one cycle; AddressB/ClockEnB sampled at edge N, QB valid after edge N, stable until next enabled edge.
- QB reset value: 16'h0000, one edge after Reset sampled low.
- No handshake; every enabled edge performs an access. Back-to-back writes and reads every cycle supported.

## Test plan
- Reset then hold: Reset low one edge -> QB=16'h0000; with ClockEnB=0 afterwards QB stays 16'h0000.
- Byte-pair assembly: write 'A'(8'h41) @12'hFFF, 'B'(8'h42) @12'hFFE, then read 11'h7FF with ClockEnB=1 -> QB=16'h4142 one edge later.
- Overwrite: write 'C'(8'h43) @12'hFFF, read 11'h7FF -> QB=16'h4342.
- Collision read-first: write 'E'(8'h45) @12'hFFE while reading 11'h7FF in the same edge (prior 8'h42) -> QB low byte 8'h42 that edge; read next edge -> 8'h45; then write 'F'(8'h46) same way -> 8'h45 then 8'h46.
- Lower half: write 'Z'(8'h5A) @12'h7FF, 'Y'(8'h59) @12'h7FE, read 11'h3FF -> QB=16'h5A59; upper half 11'h7FF unchanged.
- Enable gating: WrA=1 with ClockEnA=0 -> memory unchanged; ClockEnB=0 with changing AddressB -> QB unchanged.
